fios_pe_sequencer: RTL and testbench
====================================

# fios_pe_sequencer

Control sequencer for a single non-cascaded FIOS Montgomery processing element (PE) built around one DSP48E1. On `start_i` it runs the full FIOS schedule over `NWORDS` 17-bit words. Each cycle it emits the PE's control vector: operand-register enables, A/B/C mux selects, CREG enable, OPMODE and RES-delay enable. It also drives word indices to the operand memories and flags completion. It sits between the multiplier top-level FSM and one PE instance.

## Interface
Parameters:
- `NWORDS`, 4: operand length in 17-bit words; legal range 2..64.
- `ISSUE_GAP`, 3: cycles from one DSP op issue to the next dependent op; must equal the PE's DSP register level (1..3).

Ports:
- `clock_i` in 1: sole clock; all logic on rising edge.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `start_i` in 1: begin a multiplication; sampled only in IDLE.
- `busy_o` out 1: high from the cycle after `start_i` is accepted through the DONE cycle.
- `done_o` out 1: one-cycle pulse in the DONE state.
- `a_idx_o` out clog2(NWORDS): outer word index i; valid in LOAD.
- `bp_idx_o` out clog2(NWORDS): inner word index j for the b/p/t memories.
- `a_reg_en_o` out 1: PE a-register load.
- `m_reg_en_o` out 1: PE m-register load.
- `mux_A_sel_o` out 2: PE A-mux select (0 a_reg, 1 RES, 2 m_reg, 3 zero).
- `mux_B_sel_o` out 2: PE B-mux select (0 b, 1 p'0, 2 p, 3 zero).
- `mux_C_sel_o` out 2: PE C-mux select (0 C_i, 1 RES_delay, 2/3 delayed C).
- `CREG_en_o` out 1: DSP CREG enable.
- `OPMODE_o` out 7: DSP OPMODE.
- `RES_delay_en_o` out 1: PE RES-delay capture enable.

## Operation
- All outputs are registered.
- Idle vector: all enables 0; `mux_A_sel_o`=3, `mux_B_sel_o`=3, `mux_C_sel_o`=0; `OPMODE_o`=0x00; indices 0; `busy_o`=0; `done_o`=0.
- States: IDLE, LOAD, AB0, MQ, MCAP, MP0, ABJ, MPJ, DONE.
- Op states (AB0, MQ, MP0, ABJ, MPJ) present their op vector in the first cycle only. They then present the idle vector for ISSUE_GAP-1 wait cycles, counted by a gap counter.
- LOAD (1 cycle): `a_reg_en_o`=1; `a_idx_o`=i.
- AB0: A=0, B=0, C=0, `CREG_en_o`=1, OPMODE=0x35 (M+C): a_i·b_0+t_0; `bp_idx_o`=0.
- MQ: A=1, B=1, OPMODE=0x05 (M): q=RES·p'0; `RES_delay_en_o`=1 to hold a_i·b_0+t_0.
- MCAP (1 cycle): `m_reg_en_o`=1; captures m=RES[16:0].
- MP0: A=2, B=2, C=1, `CREG_en_o`=1, OPMODE=0x35: m·p_0+T.
- ABJ (j=1..NWORDS-1): A=0, B=0, C=0, `CREG_en_o`=1, OPMODE=0x35; `bp_idx_o`=j. C_i carries t_j plus neighbour carry.
- MPJ: A=2, B=2, C=1, `CREG_en_o`=1, OPMODE=0x35, `RES_delay_en_o`=1 on its issue cycle; `bp_idx_o`=j.
- Transitions:
  - IDLE→LOAD on `start_i`.
  - LOAD→AB0→MQ→MCAP→MP0.
  - MP0→ABJ (j=1).
  - MPJ→ABJ (j+1) while j<NWORDS-1.
  - Last MPJ→LOAD (i+1) while i<NWORDS-1, else →DONE.
  - DONE→IDLE.
- `start_i` while busy: ignored. `start_i` in the DONE cycle: ignored; accepted the next cycle.
- Counters i and j wrap to 0 on entering LOAD/DONE; they never exceed NWORDS-1.

## Timing
- `start_i` sampled high in IDLE at cycle 0 → LOAD vector at cycle 1, with `busy_o`=1.
- Iteration length: 2 + ISSUE_GAP·(2·NWORDS+1) cycles.
- Total busy cycles: NWORDS·(2+ISSUE_GAP·(2·NWORDS+1)) + 1, including DONE.
- `done_o` asserts in the last busy cycle; `busy_o` drops the cycle after.
- `reset_n_i` low at any time forces the idle vector immediately and asynchronously, and sets state to IDLE. Resuming requires a fresh `start_i` after release.

## Configuration
- `FIOS_SEQ_CYCLE_CNT_EN` defined: adds output `cycle_count_o` [15:0]. It clears on `start_i` acceptance, increments every busy cycle, holds after DONE and resets to 0.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: hold `reset_n_i` low mid-ABJ → all outputs idle vector within same cycle; `busy_o`=0; no activity until a new `start_i`.
- NWORDS=2, ISSUE_GAP=3, pulse `start_i` → `busy_o` high 35 cycles; `done_o` at cycle 35; `a_reg_en_o` pulses at cycles 1 and 18.
- NWORDS=4, ISSUE_GAP=3 → 117 busy cycles; `m_reg_en_o` pulses at cycles 8, 37, 66, 95; OPMODE 0x05 exactly 4 times.
- NWORDS=2, ISSUE_GAP=1 → no idle gaps; busy 15 cycles. Vector sequence per iteration: LOAD, AB0, MQ, MCAP, MP0, ABJ, MPJ.
- `start_i` held high continuously, NWORDS=2, ISSUE_GAP=3 → second run's LOAD at cycle 37; no re-trigger while busy.
- `FIOS_SEQ_CYCLE_CNT_EN`, NWORDS=4, ISSUE_GAP=3 → `cycle_count_o`=117 after `done_o`; clears to 0 on next start.

Source files
------------

// File: rtl/fios_pe_sequencer.sv
// FIOS Montgomery PE control sequencer: one DSP48E1, NWORDS x 17-bit words.
// Optional FIOS_SEQ_CYCLE_CNT_EN adds a 16-bit busy-cycle counter output.
module fios_pe_sequencer #(
  parameter int NWORDS    = 4,
  parameter int ISSUE_GAP = 3,
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic          clock_i,
  input  logic          reset_n_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [IW-1:0] a_idx_o,
  output logic [IW-1:0] bp_idx_o,
  output logic          a_reg_en_o,
  output logic          m_reg_en_o,
  output logic [1:0]    mux_A_sel_o,
  output logic [1:0]    mux_B_sel_o,
  output logic [1:0]    mux_C_sel_o,
  output logic          CREG_en_o,
  output logic [6:0]    OPMODE_o,
  output logic          RES_delay_en_o
`ifdef FIOS_SEQ_CYCLE_CNT_EN
  ,
  output logic [15:0]   cycle_count_o
`endif
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_AB0,
    S_MQ,
    S_MCAP,
    S_MP0,
    S_ABJ,
    S_MPJ,
    S_DONE
  } state_t;

  localparam logic [1:0]    GAP_LAST = 2'(ISSUE_GAP - 1);
  localparam logic [IW-1:0] W_LAST   = IW'(NWORDS - 1);
  localparam logic [6:0]    OP_MC    = 7'h35;
  localparam logic [6:0]    OP_M     = 7'h05;

  state_t        state_q, state_d;
  logic [1:0]    gap_q, gap_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic          adv;

  logic          busy_d, done_d;
  logic [IW-1:0] a_idx_d, bp_idx_d;
  logic          a_en_d, m_en_d;
  logic [1:0]    a_sel_d, b_sel_d, c_sel_d;
  logic          creg_d, resd_d;
  logic [6:0]    op_d;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    gap_d   = '0;
    adv     = (gap_q == GAP_LAST);
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          i_d     = '0;
          j_d     = '0;
        end
      end
      S_LOAD: state_d = S_AB0;
      S_AB0:  if (adv) state_d = S_MQ;
      S_MQ:   if (adv) state_d = S_MCAP;
      S_MCAP: state_d = S_MP0;
      S_MP0: begin
        if (adv) begin
          state_d = S_ABJ;
          j_d     = IW'(1);
        end
      end
      S_ABJ:  if (adv) state_d = S_MPJ;
      S_MPJ: begin
        if (adv) begin
          if (j_q != W_LAST) begin
            state_d = S_ABJ;
            j_d     = j_q + IW'(1);
          end else if (i_q != W_LAST) begin
            state_d = S_LOAD;
            i_d     = i_q + IW'(1);
            j_d     = '0;
          end else begin
            state_d = S_DONE;
            i_d     = '0;
            j_d     = '0;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // only op states can linger; they count out the DSP latency
    if (state_d == state_q && state_q != S_IDLE) begin
      gap_d = gap_q + 2'd1;
    end
  end

  // Vector for the state about to be entered, so every output is a flop.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    a_idx_d  = '0;
    bp_idx_d = '0;
    a_en_d   = 1'b0;
    m_en_d   = 1'b0;
    a_sel_d  = 2'd3;
    b_sel_d  = 2'd3;
    c_sel_d  = 2'd0;
    creg_d   = 1'b0;
    op_d     = '0;
    resd_d   = 1'b0;
    if (gap_d == 2'd0) begin
      unique case (1'b1)
        (state_d == S_LOAD): begin
          a_en_d  = 1'b1;
          a_idx_d = i_d;
        end
        (state_d == S_AB0): begin
          a_sel_d = 2'd0;
          b_sel_d = 2'd0;
          creg_d  = 1'b1;
          op_d    = OP_MC;
        end
        (state_d == S_MQ): begin
          a_sel_d = 2'd1;
          b_sel_d = 2'd1;
          op_d    = OP_M;
          resd_d  = 1'b1;
        end
        (state_d == S_MCAP): begin
          m_en_d = 1'b1;
        end
        (state_d == S_MP0): begin
          a_sel_d = 2'd2;
          b_sel_d = 2'd2;
          c_sel_d = 2'd1;
          creg_d  = 1'b1;
          op_d    = OP_MC;
        end
        (state_d == S_ABJ): begin
          a_sel_d  = 2'd0;
          b_sel_d  = 2'd0;
          creg_d   = 1'b1;
          op_d     = OP_MC;
          bp_idx_d = j_d;
        end
        (state_d == S_MPJ): begin
          a_sel_d  = 2'd2;
          b_sel_d  = 2'd2;
          c_sel_d  = 2'd1;
          creg_d   = 1'b1;
          op_d     = OP_MC;
          resd_d   = 1'b1;
          bp_idx_d = j_d;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      a_idx_o        <= '0;
      bp_idx_o       <= '0;
      a_reg_en_o     <= 1'b0;
      m_reg_en_o     <= 1'b0;
      mux_A_sel_o    <= 2'd3;
      mux_B_sel_o    <= 2'd3;
      mux_C_sel_o    <= 2'd0;
      CREG_en_o      <= 1'b0;
      OPMODE_o       <= '0;
      RES_delay_en_o <= 1'b0;
    end else begin
      busy_o         <= busy_d;
      done_o         <= done_d;
      a_idx_o        <= a_idx_d;
      bp_idx_o       <= bp_idx_d;
      a_reg_en_o     <= a_en_d;
      m_reg_en_o     <= m_en_d;
      mux_A_sel_o    <= a_sel_d;
      mux_B_sel_o    <= b_sel_d;
      mux_C_sel_o    <= c_sel_d;
      CREG_en_o      <= creg_d;
      OPMODE_o       <= op_d;
      RES_delay_en_o <= resd_d;
    end
  end

`ifdef FIOS_SEQ_CYCLE_CNT_EN
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cycle_count_o <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      cycle_count_o <= '0;
    end else if (state_q != S_IDLE) begin
      cycle_count_o <= cycle_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fios_pe_sequencer.sv
// Bench for fios_pe_sequencer: two configurations (4x3 and 2x1),
// table vectors, hand sequences and random starts vs a schedule model.
module tb_fios_pe_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [5:0] a_idx;
    logic [5:0] bp_idx;
    logic       a_en;
    logic       m_en;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic [1:0] c_sel;
    logic       creg;
    logic [6:0] op;
    logic       resd;
  } vec_t;

  typedef enum int {
    K_IDLE, K_WAIT, K_LOAD, K_AB0, K_MQ,
    K_MCAP, K_MP0, K_ABJ, K_MPJ, K_DONE
  } kind_t;

  typedef struct {
    logic  start;
    kind_t k;
    int    idx;
  } row_t;

  typedef vec_t vq_t[$];

  logic clk;
  logic rst_n;
  logic start_a, start_b;

  logic       busy_a, done_a, aen_a, men_a, creg_a, resd_a;
  logic [1:0] aidx_a, bpidx_a, asel_a, bsel_a, csel_a;
  logic [6:0] op_a;
  logic       busy_b, done_b, aen_b, men_b, creg_b, resd_b;
  logic [0:0] aidx_b, bpidx_b;
  logic [1:0] asel_b, bsel_b, csel_b;
  logic [6:0] op_b;
`ifdef FIOS_SEQ_CYCLE_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  vec_t got_a, got_b;
  int total = 0;
  int bad = 0;

  fios_pe_sequencer #(.NWORDS(4), .ISSUE_GAP(3)) u_a (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start_a),
    .busy_o(busy_a), .done_o(done_a),
    .a_idx_o(aidx_a), .bp_idx_o(bpidx_a),
    .a_reg_en_o(aen_a), .m_reg_en_o(men_a),
    .mux_A_sel_o(asel_a), .mux_B_sel_o(bsel_a),
    .mux_C_sel_o(csel_a), .CREG_en_o(creg_a),
    .OPMODE_o(op_a), .RES_delay_en_o(resd_a)
`ifdef FIOS_SEQ_CYCLE_CNT_EN
    , .cycle_count_o(cnt_a)
`endif
  );

  fios_pe_sequencer #(.NWORDS(2), .ISSUE_GAP(1)) u_b (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start_b),
    .busy_o(busy_b), .done_o(done_b),
    .a_idx_o(aidx_b), .bp_idx_o(bpidx_b),
    .a_reg_en_o(aen_b), .m_reg_en_o(men_b),
    .mux_A_sel_o(asel_b), .mux_B_sel_o(bsel_b),
    .mux_C_sel_o(csel_b), .CREG_en_o(creg_b),
    .OPMODE_o(op_b), .RES_delay_en_o(resd_b)
`ifdef FIOS_SEQ_CYCLE_CNT_EN
    , .cycle_count_o(cnt_b)
`endif
  );

  always_comb begin
    got_a        = '0;
    got_a.busy   = busy_a;
    got_a.done   = done_a;
    got_a.a_idx  = 6'(aidx_a);
    got_a.bp_idx = 6'(bpidx_a);
    got_a.a_en   = aen_a;
    got_a.m_en   = men_a;
    got_a.a_sel  = asel_a;
    got_a.b_sel  = bsel_a;
    got_a.c_sel  = csel_a;
    got_a.creg   = creg_a;
    got_a.op     = op_a;
    got_a.resd   = resd_a;
  end

  always_comb begin
    got_b        = '0;
    got_b.busy   = busy_b;
    got_b.done   = done_b;
    got_b.a_idx  = 6'(aidx_b);
    got_b.bp_idx = 6'(bpidx_b);
    got_b.a_en   = aen_b;
    got_b.m_en   = men_b;
    got_b.a_sel  = asel_b;
    got_b.b_sel  = bsel_b;
    got_b.c_sel  = csel_b;
    got_b.creg   = creg_b;
    got_b.op     = op_b;
    got_b.resd   = resd_b;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(kind_t k, int idx);
    vec_t v;
    v       = '0;
    v.a_sel = 2'd3;
    v.b_sel = 2'd3;
    v.busy  = (k != K_IDLE);
    case (k)
      K_LOAD: begin v.a_en = 1'b1; v.a_idx = 6'(idx); end
      K_AB0: begin
        v.a_sel = 2'd0; v.b_sel = 2'd0; v.creg = 1'b1; v.op = 7'h35;
      end
      K_MQ: begin
        v.a_sel = 2'd1; v.b_sel = 2'd1; v.op = 7'h05; v.resd = 1'b1;
      end
      K_MCAP: v.m_en = 1'b1;
      K_MP0: begin
        v.a_sel = 2'd2; v.b_sel = 2'd2; v.c_sel = 2'd1;
        v.creg = 1'b1; v.op = 7'h35;
      end
      K_ABJ: begin
        v.a_sel = 2'd0; v.b_sel = 2'd0; v.creg = 1'b1;
        v.op = 7'h35; v.bp_idx = 6'(idx);
      end
      K_MPJ: begin
        v.a_sel = 2'd2; v.b_sel = 2'd2; v.c_sel = 2'd1; v.creg = 1'b1;
        v.op = 7'h35; v.resd = 1'b1; v.bp_idx = 6'(idx);
      end
      K_DONE: v.done = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  // Expand the whole schedule: op issue followed by g-1 wait cycles.
  function automatic vq_t build(int n, int g);
    vq_t q;
    q = {};
    for (int i = 0; i < n; i++) begin
      q.push_back(mkv(K_LOAD, i));
      q.push_back(mkv(K_AB0, 0));
      for (int w = 1; w < g; w++) q.push_back(mkv(K_WAIT, 0));
      q.push_back(mkv(K_MQ, 0));
      for (int w = 1; w < g; w++) q.push_back(mkv(K_WAIT, 0));
      q.push_back(mkv(K_MCAP, 0));
      q.push_back(mkv(K_MP0, 0));
      for (int w = 1; w < g; w++) q.push_back(mkv(K_WAIT, 0));
      for (int j = 1; j < n; j++) begin
        q.push_back(mkv(K_ABJ, j));
        for (int w = 1; w < g; w++) q.push_back(mkv(K_WAIT, 0));
        q.push_back(mkv(K_MPJ, j));
        for (int w = 1; w < g; w++) q.push_back(mkv(K_WAIT, 0));
      end
    end
    q.push_back(mkv(K_DONE, 0));
    return q;
  endfunction

  task automatic chk(string nm, vec_t got, vec_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  task automatic chki(string nm, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vq_t  sched_a, sched_b;
  row_t tbl[18];
  vec_t idle_v;

  initial begin
    int busy_n, op5, done_c, pa, pb;
    int mq[$];
    int mexp[4];
    mexp = '{8, 37, 66, 95};

    tbl[0]  = '{1'b1, K_LOAD, 0};
    tbl[1]  = '{1'b1, K_AB0, 0};
    tbl[2]  = '{1'b1, K_MQ, 0};
    tbl[3]  = '{1'b1, K_MCAP, 0};
    tbl[4]  = '{1'b1, K_MP0, 0};
    tbl[5]  = '{1'b1, K_ABJ, 1};
    tbl[6]  = '{1'b1, K_MPJ, 1};
    tbl[7]  = '{1'b1, K_LOAD, 1};
    tbl[8]  = '{1'b1, K_AB0, 0};
    tbl[9]  = '{1'b1, K_MQ, 0};
    tbl[10] = '{1'b1, K_MCAP, 0};
    tbl[11] = '{1'b1, K_MP0, 0};
    tbl[12] = '{1'b1, K_ABJ, 1};
    tbl[13] = '{1'b1, K_MPJ, 1};
    tbl[14] = '{1'b1, K_DONE, 0};
    tbl[15] = '{1'b1, K_IDLE, 0};
    tbl[16] = '{1'b1, K_LOAD, 0};
    tbl[17] = '{1'b0, K_AB0, 0};

    sched_a = build(4, 3);
    sched_b = build(2, 1);
    idle_v  = mkv(K_IDLE, 0);

    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (2) tick();
    chk("reset_a", got_a, idle_v);
    chk("reset_b", got_b, idle_v);
    chki("sched_a_len", sched_a.size(), 117);
    rst_n = 1'b1;
    tick();

    // N=2 G=1 with start held high: no re-trigger, restart after DONE
    foreach (tbl[r]) begin
      start_b = tbl[r].start;
      tick();
      chk($sformatf("tbl_b[%0d]", r), got_b, mkv(tbl[r].k, tbl[r].idx));
    end
    start_b = 1'b0;
    for (int c = 0; c < 40 && busy_b; c++) tick();
    chki("drain_b_busy", int'(busy_b), 0);
    chk("drain_b_idle", got_b, idle_v);

    // N=4 G=3 full run
    busy_n = 0;
    op5    = 0;
    done_c = -1;
    start_a = 1'b1;
    for (int c = 1; c <= 118; c++) begin
      tick();
      start_a = 1'b0;
      chk($sformatf("run_a[%0d]", c), got_a,
          (c <= 117) ? sched_a[c-1] : idle_v);
      if (busy_a) busy_n++;
      if (men_a) mq.push_back(c);
      if (op_a == 7'h05) op5++;
      if (done_a) done_c = c;
    end
    chki("busy_cycles_a", busy_n, 117);
    chki("mcap_count_a", mq.size(), 4);
    for (int k = 0; k < 4; k++)
      chki($sformatf("mcap_cycle_a[%0d]", k),
           (k < mq.size()) ? mq[k] : -1, mexp[k]);
    chki("op05_count_a", op5, 4);
    chki("done_cycle_a", done_c, 117);
`ifdef FIOS_SEQ_CYCLE_CNT_EN
    chki("cycle_count_a", int'(cnt_a), 117);
`endif

    // reset asserted mid-ABJ (cycle 12 of a run)
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
`ifdef FIOS_SEQ_CYCLE_CNT_EN
    chki("cycle_count_clear", int'(cnt_a), 0);
`endif
    repeat (11) tick();
    chk("pre_rst_abj", got_a, mkv(K_ABJ, 1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", got_a, idle_v);
    tick();
    chk("held_rst_a", got_a, idle_v);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("post_rst_a[%0d]", c), got_a, idle_v);
    end

    // random starts and occasional resets against the schedule model
    pa = -1;
    pb = -1;
    for (int c = 0; c < 800; c++) begin
      start_a = ($urandom_range(0, 9) < 2);
      start_b = ($urandom_range(0, 9) < 3);
      @(posedge clk);
      if (pa < 0) begin
        if (start_a) pa = 0;
      end else begin
        pa++;
        if (pa >= sched_a.size()) pa = -1;
      end
      if (pb < 0) begin
        if (start_b) pb = 0;
      end else begin
        pb++;
        if (pb >= sched_b.size()) pb = -1;
      end
      #1;
      chk("rand_a", got_a, (pa < 0) ? idle_v : sched_a[pa]);
      chk("rand_b", got_b, (pb < 0) ? idle_v : sched_b[pb]);
      if ($urandom_range(0, 149) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rand_rst_a", got_a, idle_v);
        chk("rand_rst_b", got_b, idle_v);
        rst_n = 1'b1;
        pa = -1;
        pb = -1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
